alu_sequencer: RTL and testbench

- Control-side initiator for the 4-bit ALU: a small fetch/execute engine that issues opcode and operands to the ALU and captures its result into an accumulator.
- Holds a 16x8 program memory, loaded over a byte-wide write port while idle.
- Runs the program on a start pulse and exposes accumulator and output-register values for the chip top to route to dedicated outputs.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer that drives a clocked 4-bit ALU from a 16x8 program
// memory and collects results into an accumulator.
module alu_sequencer #(
  parameter int ALU_LAT   = 1,
  parameter int MEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  output logic [2:0] alu_opcode,
  output logic [3:0] alu_in_1,
  output logic [3:0] alu_in_2,
  input  logic [3:0] alu_result,
  output logic [3:0] acc,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_WB, S_HALTED
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] out_q, out_d;
  logic       ov_q, ov_d;
  logic [7:0] instr_q, instr_d;
  logic [2:0] op_q, op_d;
  logic [3:0] in1_q, in1_d;
  logic [3:0] in2_q, in2_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] mem_q [MEM_DEPTH];
  logic       mem_we;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    instr_d = instr_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    wcnt_d  = wcnt_q;
    mem_we  = 1'b0;
    // With ena low every register keeps its value; only the pulse is dropped.
    if (ena) begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          mem_we = prog_we;
          if (start) begin
            pc_d    = 4'd0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          instr_d = mem_q[pc_q];
          pc_d    = pc_q + 4'd1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (instr_q[7]) begin
            op_d    = instr_q[6:4];
            in1_d   = acc_q;
            in2_d   = instr_q[3:0];
            wcnt_d  = WAIT_INIT;
            state_d = S_WAIT;
          end else begin
            unique case (instr_q[6:4])
              3'b001: acc_d = instr_q[3:0];
              3'b010: pc_d  = instr_q[3:0];
              3'b011: if (acc_q == 4'd0) pc_d = instr_q[3:0];
              3'b100: begin
                out_d = acc_q;
                ov_d  = 1'b1;
              end
              3'b111: state_d = S_HALTED;
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          if (wcnt_q == 2'd0) state_d = S_WB;
          else                wcnt_d  = wcnt_q - 2'd1;
        end
        S_WB: begin
          acc_d   = alu_result;
          state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      acc_q   <= 4'd0;
      out_q   <= 4'd0;
      ov_q    <= 1'b0;
      instr_q <= 8'h00;
      op_q    <= 3'd0;
      in1_q   <= 4'd0;
      in2_q   <= 4'd0;
      wcnt_q  <= 2'd0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      instr_q <= instr_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      wcnt_q  <= wcnt_d;
      if (mem_we) mem_q[prog_addr] <= prog_data;
    end
  end

  assign alu_opcode = op_q;
  assign alu_in_1   = in1_q;
  assign alu_in_2   = in2_q;
  assign acc        = acc_q;
  assign out_data   = out_q;
  assign out_valid  = ov_q & ena;
  assign pc         = pc_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered one-cycle add/sub ALU model.
module tb_alu_sequencer;

  logic       clk, rst_n, ena, prog_we, start;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in_1, alu_in_2, alu_result;
  logic [3:0] acc, out_data, pc;
  logic       out_valid, busy, halted;

  int tests = 0;
  int fails = 0;
  int r_cyc, r_ovc, inj_err;

  alu_sequencer #(.ALU_LAT(1), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
    .alu_opcode(alu_opcode), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_result(alu_result), .acc(acc), .out_data(out_data),
    .out_valid(out_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  // Registered ALU: 000 add mod 16, 001 sub mod 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_result <= 4'd0;
    else begin
      case (alu_opcode)
        3'b000:  alu_result <= alu_in_1 + alu_in_2;
        3'b001:  alu_result <= alu_in_1 - alu_in_2;
        default: alu_result <= 4'd0;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] i0;
    logic [7:0] i1;
    int         acc;
    int         out;
    int         ov;
    int         cyc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < 4; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = w[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  // kind: 0 plain, 1 write+start while busy, 2 ena low 5 cycles in WAIT, 3 alu hold watch
  task automatic run_prog(input int kind, input int limit);
    int cnt;
    logic [3:0] pc_s, acc_s;
    cnt = -1; r_ovc = 0; inj_err = 0;
    start = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      prog_we = 1'b0;
      if (out_valid) r_ovc++;
      if (kind == 1 && cnt == 3) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'hFF;
      end
      if (kind == 2 && cnt == 4) begin
        pc_s = pc; acc_s = acc; ena = 1'b0;
        repeat (5) begin
          @(negedge clk);
          cnt++;
          if (pc !== pc_s || acc !== acc_s || !busy || out_valid) inj_err++;
        end
        ena = 1'b1;
      end
      if (kind == 3) begin
        if (cnt <= 3 && alu_in_2 !== 4'd0) inj_err++;
        if (cnt >= 4 && {alu_opcode, alu_in_1, alu_in_2} !== {3'd0, 4'd2, 4'd7}) inj_err++;
      end
    end while (!halted && cnt < limit);
    r_cyc = cnt;
  endtask

  initial begin
    int  seen_loop, acc_at_loop, busy_err, seen_wrap, bad;
    logic [3:0] pc_prev;

    vecs[0] = '{8'h15, 8'h83,  8,  8, 1, 10};
    vecs[1] = '{8'h1F, 8'h81,  0,  0, 1, 10};
    vecs[2] = '{8'h10, 8'h91, 15, 15, 1, 10};
    vecs[3] = '{8'h1C, 8'h95,  7,  7, 1, 10};
    vecs[4] = '{8'h13, 8'h50,  3,  3, 1,  8};
    vecs[5] = '{8'h1A, 8'h09, 10, 10, 1,  8};
    vecs[6] = '{8'h16, 8'h23,  6,  0, 0,  6};
    vecs[7] = '{8'h10, 8'h33,  0,  0, 0,  6};
    vecs[8] = '{8'h14, 8'h33,  4,  4, 1,  8};

    rst_n = 1'b0; ena = 1'b1; prog_we = 1'b0; start = 1'b0;
    prog_addr = 4'd0; prog_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("reset_pc", int'(pc), 0);
    check("reset_acc", int'(acc), 0);
    check("reset_out", int'({out_data, out_valid}), 0);
    check("reset_flags", int'({busy, halted}), 0);
    check("reset_alu", int'({alu_opcode, alu_in_1, alu_in_2}), 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      load4(vecs[v].i0, vecs[v].i1, 8'h40, 8'h70);
      run_prog(0, 60);
      check($sformatf("vec%0d_cycles", v), r_cyc, vecs[v].cyc);
      check($sformatf("vec%0d_acc", v), int'(acc), vecs[v].acc);
      check($sformatf("vec%0d_out", v), int'(out_data), vecs[v].out);
      check($sformatf("vec%0d_pulses", v), r_ovc, vecs[v].ov);
      check($sformatf("vec%0d_pc", v), int'(pc), 4);
      check($sformatf("vec%0d_halted", v), int'({halted, busy}), 2);
    end

    // ALU outputs held through WAIT/WB and afterwards
    do_reset();
    load4(8'h12, 8'h87, 8'h70, 8'h00);
    run_prog(3, 40);
    check("hold_cycles", r_cyc, 8);
    check("hold_acc", int'(acc), 9);
    check("hold_alu_stable", inj_err, 0);

    // Program write and start while busy are both ignored
    do_reset();
    load4(8'h15, 8'h83, 8'h40, 8'h70);
    run_prog(1, 60);
    check("busywr_cycles", r_cyc, 10);
    check("busywr_out", int'(out_data), 8);
    check("busywr_pulses", r_ovc, 1);
    check("busywr_pc", int'(pc), 4);
    run_prog(0, 60);
    check("readback_cycles", r_cyc, 10);
    check("readback_acc", int'(acc), 8);
    check("readback_pulses", r_ovc, 1);
    check("readback_halted", int'(halted), 1);

    // Enable dropped for 5 cycles in WAIT
    do_reset();
    load4(8'h15, 8'h83, 8'h40, 8'h70);
    run_prog(2, 60);
    check("ena_frozen", inj_err, 0);
    check("ena_cycles", r_cyc, 15);
    check("ena_acc", int'(acc), 8);
    check("ena_out", int'(out_data), 8);
    check("ena_pulses", r_ovc, 1);
    check("ena_pc", int'(pc), 4);

    // Wrap to zero then JZ 0 loops forever
    do_reset();
    load4(8'h1F, 8'h81, 8'h30, 8'h70);
    start = 1'b1;
    seen_loop = 0; acc_at_loop = -1; busy_err = 0; pc_prev = 4'd0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pc_prev == 4'd3 && pc == 4'd0 && seen_loop == 0) begin
        seen_loop = 1;
        acc_at_loop = int'(acc);
      end
      if (!busy || halted) busy_err++;
      pc_prev = pc;
    end
    check("jz_loop_taken", seen_loop, 1);
    check("jz_acc_wrapped", acc_at_loop, 0);
    check("jz_busy_no_halt", busy_err, 0);

    // Async reset mid-WAIT clears everything before the next edge
    do_reset();
    load4(8'h15, 8'h83, 8'h40, 8'h70);
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc_acc", int'({pc, acc}), 0);
    check("async_out", int'({out_data, out_valid}), 0);
    check("async_flags", int'({busy, halted}), 0);
    check("async_alu", int'({alu_opcode, alu_in_1, alu_in_2}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    seen_wrap = 0; bad = 0; pc_prev = 4'd0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pc_prev == 4'd15 && pc == 4'd0) seen_wrap = 1;
      if (halted || out_valid || acc != 4'd0) bad++;
      pc_prev = pc;
    end
    check("erased_nop_run", bad, 0);
    check("pc_wrap", seen_wrap, 1);
    check("erased_busy", int'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
